// File: rtl/wbucw_drain.sv
// Codeword FIFO drain: pops CW-bit words and serializes them MSB-first
// as OW-bit chunks on a valid/busy stream, with an optional keep-alive word.
module wbucw_drain #(
  parameter int              CW            = 36,
  parameter int              OW            = 6,
  parameter int              LGIDLE        = 20,
  parameter bit              OPT_KEEPALIVE = 1'b1,
  parameter logic [CW-1:0]   IDLE_WORD     = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_fifo_empty_n,
  input  logic [CW-1:0] i_fifo_data,
  output logic          o_fifo_rd,
  output logic          o_stb,
  output logic [OW-1:0] o_chunk,
  output logic          o_last,
  input  logic          i_busy,
  output logic          o_idle
);

  localparam int NCHUNK = CW / OW;
  localparam int RW     = $clog2(NCHUNK) + 1;

  generate
    if (CW % OW != 0) begin : g_bad_width
      $error("wbucw_drain: CW must be a multiple of OW");
    end
  endgenerate

  logic [CW-1:0]     sreg;
  logic [RW-1:0]     remain;
  logic [LGIDLE-1:0] idle_ctr;

  logic          adv;
  logic          have_rem;
  logic          load_fifo;
  logic          ka_fire;
  logic [CW-1:0] load_word;

  assign adv       = !o_stb || !i_busy;
  assign have_rem  = (remain != '0);
  assign load_fifo = adv && !have_rem && i_fifo_empty_n;
  // FIFO data always wins over the keep-alive word
  assign ka_fire   = OPT_KEEPALIVE && (&idle_ctr) && adv
                     && !have_rem && !i_fifo_empty_n;
  assign load_word = i_fifo_empty_n ? i_fifo_data : IDLE_WORD;

  assign o_fifo_rd = load_fifo && !i_reset;
  assign o_idle    = !o_stb && !have_rem && !i_fifo_empty_n;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stb    <= 1'b0;
      o_last   <= 1'b0;
      o_chunk  <= '0;
      sreg     <= '0;
      remain   <= '0;
      idle_ctr <= '0;
    end else begin
      if (adv) begin
        if (have_rem) begin
          o_chunk <= sreg[CW-1 -: OW];
          sreg    <= sreg << OW;
          remain  <= remain - 1'b1;
          o_stb   <= 1'b1;
          o_last  <= (remain == RW'(1));
        end else if (load_fifo || ka_fire) begin
          o_chunk <= load_word[CW-1 -: OW];
          sreg    <= load_word << OW;
          remain  <= RW'(NCHUNK - 1);
          o_stb   <= 1'b1;
          o_last  <= (NCHUNK == 1);
        end else begin
          o_stb  <= 1'b0;
          o_last <= 1'b0;
        end
      end
      if (o_stb || i_fifo_empty_n || have_rem || ka_fire)
        idle_ctr <= '0;
      else if (!(&idle_ctr))
        idle_ctr <= idle_ctr + 1'b1;
    end
  end

endmodule

// File: tb/tb_wbucw_drain.sv
// Bench for wbucw_drain: directed steps plus random traffic checked
// against a chunk-stream scoreboard with a quiet-period keep-alive model.
module tb_wbucw_drain;

  localparam int CW  = 36;
  localparam int OW  = 6;
  localparam int NCH = CW / OW;

  logic          i_clk   = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_busy  = 1'b0;
  logic          o_fifo_rd;
  logic          o_stb;
  logic          o_last;
  logic          o_idle;
  logic [OW-1:0] o_chunk;

  logic [CW-1:0] mem [0:255];
  logic [7:0]    wr_cnt = '0;
  logic [7:0]    rd_cnt = '0;

  wire           i_fifo_empty_n = (wr_cnt != rd_cnt);
  wire [CW-1:0]  i_fifo_data    = mem[rd_cnt];

  always #5 i_clk = ~i_clk;

  wbucw_drain #(
    .CW(CW), .OW(OW), .LGIDLE(4),
    .OPT_KEEPALIVE(1'b1), .IDLE_WORD('0)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_fifo_empty_n(i_fifo_empty_n),
    .i_fifo_data(i_fifo_data),
    .o_fifo_rd(o_fifo_rd),
    .o_stb(o_stb),
    .o_chunk(o_chunk),
    .o_last(o_last),
    .i_busy(i_busy),
    .o_idle(o_idle)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int quiet_run = 0;
  bit hold_v   = 1'b0;
  logic [OW-1:0] hold_c;
  logic          hold_l;
  logic [6:0]    exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void push_exp(input logic [CW-1:0] w);
    logic [CW-1:0] t;
    t = w;
    for (int k = 0; k < NCH; k++) begin
      exp_q.push_back({(k == NCH - 1), t[CW-1 -: OW]});
      t = t << OW;
    end
  endfunction

  // scoreboard: pre-edge view of every cycle
  always @(posedge i_clk) begin
    if (i_reset) begin
      chk("rd_in_reset", {63'd0, o_fifo_rd}, 64'd0);
      exp_q.delete();
      quiet_run = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_stb", {63'd0, o_stb}, 64'd1);
        chk("stall_chunk", {58'd0, o_chunk}, {58'd0, hold_c});
        chk("stall_last", {63'd0, o_last}, {63'd0, hold_l});
      end
      hold_v = o_stb && i_busy;
      hold_c = o_chunk;
      hold_l = o_last;
      chk("idle_flag", {63'd0, o_idle},
          {63'd0, (!o_stb && !i_fifo_empty_n)});
      if (o_fifo_rd) begin
        chk("rd_when_empty", {63'd0, i_fifo_empty_n}, 64'd1);
        chk("rd_timing", {63'd0, (!o_stb || (o_last && !i_busy))}, 64'd1);
      end
      if (o_stb && !i_busy) begin
        if (exp_q.size() == 0)
          chk("chunk_available", 64'd0, 64'd1);
        else
          chk("stream", {57'd0, o_last, o_chunk},
              {57'd0, exp_q.pop_front()});
      end
      if (o_fifo_rd) begin
        pops++;
        push_exp(i_fifo_data);
        rd_cnt <= rd_cnt + 8'd1;
      end
      if (!o_stb && !i_fifo_empty_n) begin
        if (quiet_run == 15) begin
          push_exp('0);
          quiet_run = 0;
        end else begin
          quiet_run++;
        end
      end else begin
        quiet_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] w);
    mem[wr_cnt] = w;
    wr_cnt = wr_cnt + 8'd1;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (o_stb && c < 60) begin
      tick();
      c++;
    end
    chk(tag, {63'd0, o_stb}, 64'd0);
  endtask

  logic [5:0]    tbl [6];
  logic [CW-1:0] w;
  int            p0;
  int            n;
  int            lp;

  initial begin
    tbl = '{6'h04, 6'h23, 6'h11, 6'h16, 6'h1E, 6'h09};

    // reset with empty FIFO
    repeat (16) tick();
    chk("rst_stb", {63'd0, o_stb}, 64'd0);
    chk("rst_rd", {63'd0, o_fifo_rd}, 64'd0);
    chk("rst_idle", {63'd0, o_idle}, 64'd1);
    chk("rst_chunk", {58'd0, o_chunk}, 64'd0);
    chk("rst_last", {63'd0, o_last}, 64'd0);

    // single word
    i_reset = 1'b0;
    push(36'h123456789);
    #1;
    chk("t2_rd", {63'd0, o_fifo_rd}, 64'd1);
    p0 = pops;
    tick();
    chk("t2_pop", pops, p0 + 1);
    for (int i = 0; i < 6; i++) begin
      chk("t2_stb", {63'd0, o_stb}, 64'd1);
      chk("t2_chunk", {58'd0, o_chunk}, {58'd0, tbl[i]});
      chk("t2_last", {63'd0, o_last}, {63'd0, (i == 5)});
      tick();
    end
    chk("t2_end", {63'd0, o_stb}, 64'd0);
    chk("t2_pops", pops, p0 + 1);

    // two words back to back
    push(CW'({$urandom(), $urandom()}));
    push(CW'({$urandom(), $urandom()}));
    n = 0;
    lp = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_stb) begin
        n++;
        if (o_last) lp++;
      end else if (n > 0) begin
        break;
      end
      tick();
    end
    chk("t3_run", n, 12);
    chk("t3_lasts", lp, 2);

    // stall on chunk 2
    push(36'h123456789);
    p0 = pops;
    tick();
    tick();
    i_busy = 1'b1;
    repeat (5) begin
      tick();
      chk("t4_hold_chunk", {58'd0, o_chunk}, 64'h23);
      chk("t4_hold_stb", {63'd0, o_stb}, 64'd1);
    end
    i_busy = 1'b0;
    drain("t4_drain");
    chk("t4_pops", pops, p0 + 1);

    // keep-alive after the quiet period
    p0 = pops;
    n = 0;
    while (!o_stb && n < 40) begin
      tick();
      n++;
    end
    chk("t5_delay", n, 16);
    for (int i = 0; i < 6; i++) begin
      chk("t5_chunk", {58'd0, o_chunk}, 64'd0);
      chk("t5_last", {63'd0, o_last}, {63'd0, (i == 5)});
      tick();
    end
    chk("t5_pops", pops, p0);
    chk("t5_end", {63'd0, o_stb}, 64'd0);

    // FIFO word arriving as the timer saturates wins
    repeat (15) tick();
    push(36'h123456789);
    #1;
    chk("t5b_rd", {63'd0, o_fifo_rd}, 64'd1);
    tick();
    chk("t5b_chunk", {58'd0, o_chunk}, 64'h04);
    drain("t5b_drain");

    // reset mid-word
    push(CW'({$urandom(), $urandom()}));
    repeat (4) tick();
    i_reset = 1'b1;
    tick();
    chk("t6_stb", {63'd0, o_stb}, 64'd0);
    chk("t6_last", {63'd0, o_last}, 64'd0);
    chk("t6_chunk", {58'd0, o_chunk}, 64'd0);
    i_reset = 1'b0;
    w = CW'({$urandom(), $urandom()});
    push(w);
    tick();
    chk("t6_first", {58'd0, o_chunk}, {58'd0, w[CW-1 -: OW]});
    chk("t6_first_stb", {63'd0, o_stb}, 64'd1);
    drain("t6_drain");

    // random traffic with random stalls
    for (int c = 0; c < 600; c++) begin
      i_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0)
        push(CW'({$urandom(), $urandom()}));
      tick();
    end
    i_busy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_fifo_empty_n && !o_stb) break;
      tick();
    end
    chk("rnd_fifo_empty", {63'd0, i_fifo_empty_n}, 64'd0);
    chk("rnd_stb", {63'd0, o_stb}, 64'd0);
    chk("rnd_scoreboard", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
